// File: rtl/stereo_pixel_streamer_if.sv
// rtl/stereo_pixel_streamer_if.sv - start/done control, frame-memory read port and pixel-pair stream
// master is the streamer side, slave is the environment (memories, downstream, sequencer).
interface stereo_pixel_streamer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        left_mem_data;
  logic [7:0]        right_mem_data;
  logic              out_ready;
  logic [7:0]        left_pixel;
  logic [7:0]        right_pixel;
  logic              pixel_valid;
  logic              line_start;
  logic              frame_last;

  modport master (
    input  start,
    output busy,
    output done,
    output mem_rd_en,
    output mem_addr,
    input  left_mem_data,
    input  right_mem_data,
    input  out_ready,
    output left_pixel,
    output right_pixel,
    output pixel_valid,
    output line_start,
    output frame_last
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  mem_rd_en,
    input  mem_addr,
    output left_mem_data,
    output right_mem_data,
    output out_ready,
    input  left_pixel,
    input  right_pixel,
    input  pixel_valid,
    input  line_start,
    input  frame_last
  );
endinterface

// File: rtl/stereo_pixel_streamer.sv
// rtl/stereo_pixel_streamer.sv - raster reader for a stereo frame pair feeding a pixel-pair stream
// Reads are throttled so read data always has a home in the output register or skid FIFO.
module stereo_pixel_streamer #(
  parameter int FRAME_WIDTH   = 272,
  parameter int FRAME_HEIGHT  = 240,
  parameter int HBLANK_CYCLES = 4,
  parameter int ADDR_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  stereo_pixel_streamer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_FLUSH} state_t;

  localparam logic [8:0] X_LAST = 9'(FRAME_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(FRAME_HEIGHT - 1);
  localparam int         GAP_W  = $clog2(HBLANK_CYCLES + 2);
  // The first read of a line reaches the output two cycles after issue, so those
  // two cycles already count towards the blanking gap.
  localparam logic [GAP_W:0] GAP_TGT = (HBLANK_CYCLES > 2) ? (GAP_W + 1)'(HBLANK_CYCLES - 2) : '0;

  state_t            state_q, state_d;
  logic [8:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_ls_q, rd_ls_d;
  logic              rd_fl_q, rd_fl_d;
  logic              out_valid_q, out_valid_d;
  logic [17:0]       out_data_q, out_data_d;
  logic [17:0]       fifo_mem_q [2];
  logic [17:0]       fifo_mem_d [2];
  logic              fifo_wr_q, fifo_wr_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              done_q, done_d;

  logic              xfer;
  logic [2:0]        occ;
  logic              rd_en;
  logic              line_end;
  logic              frame_end;
  logic [17:0]       in_data;
  logic              out_free;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drained_now;
  logic              drained_after;
  logic [GAP_W:0]    gap_sum;

  always_comb begin
    xfer      = out_valid_q && bus.out_ready;
    // Entries still owed a slot after this cycle; a third would have nowhere to land.
    occ       = {2'b00, out_valid_q} + {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, xfer};
    rd_en     = (state_q == S_ACTIVE) && (occ < 3'd2);
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);
    in_data   = {rd_ls_q, rd_fl_q, bus.left_mem_data, bus.right_mem_data};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fifo_mem_d  = fifo_mem_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    out_free    = !out_valid_q || xfer;
    rd_pend_d   = rd_en;
    rd_ls_d     = (x_q == 9'd0);
    rd_fl_d     = frame_end;
    done_d      = xfer && out_data_q[16];

    if (out_free) begin
      if (fifo_cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_mem_q[fifo_rd_q];
        fifo_pop    = 1'b1;
        fifo_push   = rd_pend_q;
      end else if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      fifo_push = rd_pend_q;
    end

    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = in_data;
      fifo_wr_d             = ~fifo_wr_q;
    end
    if (fifo_pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    gap_d         = gap_q;
    drained_now   = !out_valid_q && (fifo_cnt_q == 2'd0) && !rd_pend_q;
    drained_after = (fifo_cnt_q == 2'd0) && !rd_pend_q && (!out_valid_q || xfer);
    gap_sum       = {1'b0, gap_q} + {{GAP_W{1'b0}}, drained_now};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          gap_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (rd_en) begin
          addr_d = addr_q + ADDR_W'(1);
          if (line_end) begin
            x_d     = '0;
            y_d     = frame_end ? 9'd0 : y_q + 9'd1;
            gap_d   = '0;
            state_d = frame_end ? S_FLUSH : S_HBLANK;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      S_HBLANK: begin
        if (drained_after && (gap_sum >= GAP_TGT)) begin
          state_d = S_ACTIVE;
          gap_d   = '0;
        end else begin
          gap_d = gap_sum[GAP_W-1:0];
        end
      end
      S_FLUSH: begin
        if (done_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      gap_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_ls_q     <= 1'b0;
      rd_fl_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fifo_mem_q  <= '{default: '0};
      fifo_wr_q   <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      rd_pend_q   <= rd_pend_d;
      rd_ls_q     <= rd_ls_d;
      rd_fl_q     <= rd_fl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      fifo_mem_q  <= fifo_mem_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = addr_q;
  assign bus.left_pixel  = out_data_q[15:8];
  assign bus.right_pixel = out_data_q[7:0];
  assign bus.pixel_valid = out_valid_q;
  assign bus.line_start  = out_valid_q && out_data_q[17];
  assign bus.frame_last  = out_valid_q && out_data_q[16];

endmodule
